peripheral_arbiter_ahb3: RTL and testbench

Round-robin AHB3-Lite interconnect stage that shares one AHB3-Lite slave (e.g. `peripheral_timer_ahb3` or an MPRAM port) between `MASTERS` AHB3-Lite masters (BFMs or cores). It sits between the masters and the slave. It owns the address-phase grant and tracks the data-phase owner. Losing masters are stalled through their `HREADYOUT` while they hold their address. Bursts and locked sequences are never broken.

---
 rtl/peripheral_ahb3_pkg.sv | 28 ++
 rtl/peripheral_arb_rr_ahb3.sv | 27 ++
 rtl/peripheral_arbiter_ahb3.sv | 127 ++++++++++++
 tb/tb_peripheral_arbiter_ahb3.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings for the peripheral interconnect blocks.
package peripheral_ahb3_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_arb_rr_ahb3.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// never returning 'last' itself (the caller parks on it when nothing is found).
module peripheral_arb_rr_ahb3 #(
  parameter int MASTERS = 2,
  parameter int IW      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      next,
  output logic               found
);

  always_comb begin
    int idx;
    idx   = 0;
    next  = last;
    found = 1'b0;
    for (int k = 1; k < MASTERS; k++) begin
      idx = (int'(last) + k) % MASTERS;
      if (!found && req[idx]) begin
        next  = IW'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_ahb3.sv
// Round-robin AHB3-Lite stage sharing one slave between MASTERS masters.
// Tracks the address-phase owner and the data-phase owner separately.
module peripheral_arbiter_ahb3
  import peripheral_ahb3_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,

  input  logic [MASTERS-1:0]    mst_HSEL,
  input  logic [HADDR_SIZE-1:0] mst_HADDR     [MASTERS],
  input  logic [HDATA_SIZE-1:0] mst_HWDATA    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HWRITE,
  input  logic [2:0]            mst_HSIZE     [MASTERS],
  input  logic [2:0]            mst_HBURST    [MASTERS],
  input  logic [3:0]            mst_HPROT     [MASTERS],
  input  logic [1:0]            mst_HTRANS    [MASTERS],
  input  logic [MASTERS-1:0]    mst_HMASTLOCK,
  output logic [HDATA_SIZE-1:0] mst_HRDATA,
  output logic [MASTERS-1:0]    mst_HREADYOUT,
  output logic [MASTERS-1:0]    mst_HRESP,

  output logic                  slv_HSEL,
  output logic [HADDR_SIZE-1:0] slv_HADDR,
  output logic [HDATA_SIZE-1:0] slv_HWDATA,
  output logic                  slv_HWRITE,
  output logic [2:0]            slv_HSIZE,
  output logic [2:0]            slv_HBURST,
  output logic [3:0]            slv_HPROT,
  output logic [1:0]            slv_HTRANS,
  output logic                  slv_HMASTLOCK,
  output logic                  slv_HREADY,
  input  logic [HDATA_SIZE-1:0] slv_HRDATA,
  input  logic                  slv_HREADYOUT,
  input  logic                  slv_HRESP
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [IW-1:0]      owner_q,  owner_d;
  logic [IW-1:0]      downer_q, downer_d;
  logic               dvalid_q, dvalid_d;
  logic [MASTERS-1:0] req;
  logic [IW-1:0]      rr_next;
  logic               rr_found;
  logic [1:0]         own_trans;
  logic               arb_ok;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) req[i] = mst_HSEL[i] & mst_HTRANS[i][1];
  end

  peripheral_arb_rr_ahb3 #(
    .MASTERS (MASTERS),
    .IW      (IW)
  ) u_rr (
    .req   (req),
    .last  (owner_q),
    .next  (rr_next),
    .found (rr_found)
  );

  // A burst (SEQ/BUSY) or locked sequence keeps the grant; switching waits
  // until the owner shows IDLE or starts a fresh NONSEQ.
  assign own_trans = mst_HTRANS[owner_q];
  assign arb_ok    = slv_HREADYOUT & ~mst_HMASTLOCK[owner_q]
                   & (own_trans != HTRANS_BUSY) & (own_trans != HTRANS_SEQ);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    owner_d  = owner_q;
    dvalid_d = dvalid_q;
    downer_d = downer_q;
    if (slv_HREADYOUT) begin
      dvalid_d = req[owner_q];
      downer_d = owner_q;
      if (arb_ok && rr_found) owner_d = rr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q  <= '0;
      dvalid_q <= 1'b0;
      downer_q <= '0;
    end else begin
      owner_q  <= owner_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
    end
  end

  assign slv_HSEL      = mst_HSEL[owner_q];
  assign slv_HADDR     = mst_HADDR[owner_q];
  assign slv_HWRITE    = mst_HWRITE[owner_q];
  assign slv_HSIZE     = mst_HSIZE[owner_q];
  assign slv_HBURST    = mst_HBURST[owner_q];
  assign slv_HPROT     = mst_HPROT[owner_q];
  assign slv_HMASTLOCK = mst_HMASTLOCK[owner_q];
  assign slv_HTRANS    = mst_HSEL[owner_q] ? own_trans : HTRANS_IDLE;
  assign slv_HWDATA    = mst_HWDATA[downer_q];
  assign slv_HREADY    = slv_HREADYOUT;
  assign mst_HRDATA    = slv_HRDATA;

  // Data-phase owner has priority: it may also be the new address owner.
  always_comb begin
    mst_HREADYOUT = '1;
    mst_HRESP     = {MASTERS{HRESP_OKAY}};
    for (int i = 0; i < MASTERS; i++) begin
      if (dvalid_q && downer_q == IW'(i)) begin
        mst_HREADYOUT[i] = slv_HREADYOUT;
        mst_HRESP[i]     = slv_HRESP;
      end else if (owner_q == IW'(i)) begin
        mst_HREADYOUT[i] = slv_HREADYOUT;
      end else if (req[i]) begin
        mst_HREADYOUT[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter_ahb3.sv
// Bench for peripheral_arbiter_ahb3: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model of the arbitration rules.
module tb_peripheral_arbiter_ahb3;
  import peripheral_ahb3_pkg::*;

  localparam int M  = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic [M-1:0]  sel, wr, lock;
  logic [AW-1:0] addr  [M];
  logic [DW-1:0] wdata [M];
  logic [2:0]    size  [M];
  logic [2:0]    burst [M];
  logic [3:0]    prot  [M];
  logic [1:0]    trans [M];
  logic [DW-1:0] mst_HRDATA;
  logic [M-1:0]  mst_HREADYOUT, mst_HRESP;
  logic          slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADY;
  logic [AW-1:0] slv_HADDR;
  logic [DW-1:0] slv_HWDATA, slv_HRDATA;
  logic [2:0]    slv_HSIZE, slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic          s_ready = 1'b1, s_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  peripheral_arbiter_ahb3 #(.MASTERS(M), .HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mst_HSEL(sel), .mst_HADDR(addr), .mst_HWDATA(wdata), .mst_HWRITE(wr),
    .mst_HSIZE(size), .mst_HBURST(burst), .mst_HPROT(prot), .mst_HTRANS(trans),
    .mst_HMASTLOCK(lock), .mst_HRDATA(mst_HRDATA), .mst_HREADYOUT(mst_HREADYOUT),
    .mst_HRESP(mst_HRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HREADY(slv_HREADY), .slv_HRDATA(slv_HRDATA), .slv_HREADYOUT(s_ready),
    .slv_HRESP(s_resp)
  );

  initial forever #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Simple memory slave; its wait/error behaviour comes from s_ready/s_resp.
  logic [AW-1:0] sp_addr;
  logic          sp_write, sp_valid;
  logic [DW-1:0] mem [64];
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sp_valid <= 1'b0;
      sp_write <= 1'b0;
      sp_addr  <= '0;
    end else if (slv_HREADY) begin
      if (sp_valid && sp_write) mem[sp_addr[7:2]] <= slv_HWDATA;
      sp_valid <= slv_HSEL && slv_HTRANS[1];
      sp_addr  <= slv_HADDR;
      sp_write <= slv_HWRITE;
    end
  end
  assign slv_HRDATA = mem[sp_addr[7:2]];

  // ---------------- reference model ----------------
  int m_owner, m_downer;
  bit m_dvalid;

  function automatic bit m_req(input int i);
    return sel[i] && trans[i][1];
  endfunction

  function automatic bit exp_ready(input int i);
    if (m_dvalid && m_downer == i) return s_ready;
    if (i == m_owner) return s_ready;
    if (m_req(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_resp(input int i);
    return (m_dvalid && m_downer == i) ? s_resp : 1'b0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_downer = 0; m_dvalid = 0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  may_switch;
    if (!HRESETn) begin model_reset(); return; end
    if (!s_ready) return;
    nxt = m_owner;
    may_switch = !lock[m_owner] && trans[m_owner] != HTRANS_BUSY && trans[m_owner] != HTRANS_SEQ;
    if (may_switch) begin
      for (int k = 1; k < M; k++) begin
        if (m_req((m_owner + k) % M)) begin nxt = (m_owner + k) % M; break; end
      end
    end
    m_dvalid = m_req(m_owner);
    m_downer = m_owner;
    m_owner  = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input int i, input bit s, input logic [1:0] t, input bit w,
                       input logic [AW-1:0] a, input logic [2:0] b, input bit l);
    sel[i] = s; trans[i] = t; wr[i] = w; addr[i] = a; burst[i] = b; lock[i] = l;
    size[i] = HSIZE_WORD; prot[i] = 4'b0011;
  endtask

  task automatic idle_all();
    for (int i = 0; i < M; i++) begin
      set_m(i, 1'b0, HTRANS_IDLE, 1'b0, AW'(16'hA000 + i * 16'h0100), HBURST_SINGLE, 1'b0);
      wdata[i] = 32'h1111_0000 + DW'(i);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic reset_dut();
    idle_all();
    s_ready = 1'b1; s_resp = 1'b0;
    HRESETn = 1'b0;
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_all();
    s_ready = 1'b0; s_resp = 1'b1;
    #1 HRESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (mst_HREADYOUT !== 3'b110) begin errors++; $display("FAIL reset_ready_wait: got %b want 110", mst_HREADYOUT); end
    checks++; if (mst_HRESP !== 3'b000) begin errors++; $display("FAIL reset_resp: got %b want 000", mst_HRESP); end
    checks++; if (slv_HADDR !== addr[0]) begin errors++; $display("FAIL reset_owner_addr: got %h want %h", slv_HADDR, addr[0]); end
    checks++; if (slv_HSEL !== 1'b0 || slv_HTRANS !== HTRANS_IDLE) begin errors++; $display("FAIL reset_slv_idle: got sel %b trans %b want 0 00", slv_HSEL, slv_HTRANS); end
    s_ready = 1'b1;
    #1;
    checks++; if (mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", mst_HREADYOUT); end
    checks++; if (slv_HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", slv_HREADY); end
    s_resp = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write_read();
    reset_dut();
    set_m(0, 1'b1, HTRANS_NONSEQ, 1'b1, 16'h0010, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL swr_wr_addr_ready: got %b want 111", mst_HREADYOUT); end
    checks++; if (slv_HADDR !== 16'h0010 || slv_HWRITE !== 1'b1) begin errors++; $display("FAIL swr_wr_addr: got %h/%b want 0010/1", slv_HADDR, slv_HWRITE); end
    tick();
    set_m(0, 1'b1, HTRANS_IDLE, 1'b0, 16'h0010, HBURST_SINGLE, 1'b0);
    wdata[0] = 32'hCAFE_0001;
    @(negedge HCLK);
    checks++; if (slv_HWDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL swr_wdata: got %h want cafe0001", slv_HWDATA); end
    checks++; if (mst_HREADYOUT[1] !== 1'b1) begin errors++; $display("FAIL swr_m1_ready_wr: got %b want 1", mst_HREADYOUT[1]); end
    tick();
    set_m(0, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0010, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL swr_rd_addr_ready: got %b want 111", mst_HREADYOUT); end
    tick();
    set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0010, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HRDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL swr_rdata: got %h want cafe0001", mst_HRDATA); end
    checks++; if (mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL swr_rd_data_ready: got %b want 111", mst_HREADYOUT); end
    tick();
  endtask

  task automatic test_contention();
    reset_dut();
    set_m(0, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0100, HBURST_SINGLE, 1'b0);
    set_m(1, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0200, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT !== 3'b101) begin errors++; $display("FAIL cont_first: got %b want 101", mst_HREADYOUT); end
    checks++; if (slv_HADDR !== 16'h0100) begin errors++; $display("FAIL cont_addr0: got %h want 0100", slv_HADDR); end
    tick();
    set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0100, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT[1] !== 1'b1) begin errors++; $display("FAIL cont_m1_granted: got %b want 1", mst_HREADYOUT[1]); end
    checks++; if (slv_HADDR !== 16'h0200 || slv_HTRANS !== HTRANS_NONSEQ) begin errors++; $display("FAIL cont_addr1: got %h/%b want 0200/10", slv_HADDR, slv_HTRANS); end
    tick();
    set_m(1, 1'b0, HTRANS_IDLE, 1'b0, 16'h0200, HBURST_SINGLE, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL cont_done: got %b want 111", mst_HREADYOUT); end
    tick();
  endtask

  task automatic test_burst_hold();
    reset_dut();
    set_m(1, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0040, HBURST_INCR4, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT[1] !== 1'b0) begin errors++; $display("FAIL burst_stall_first: got %b want 0", mst_HREADYOUT[1]); end
    tick();
    @(negedge HCLK);
    checks++; if (slv_HADDR !== 16'h0040 || mst_HREADYOUT[1] !== 1'b1) begin errors++; $display("FAIL burst_beat1: got %h/%b want 0040/1", slv_HADDR, mst_HREADYOUT[1]); end
    tick();
    set_m(0, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0080, HBURST_SINGLE, 1'b0);
    for (int b = 1; b < 4; b++) begin
      set_m(1, 1'b1, HTRANS_SEQ, 1'b0, AW'(16'h0040 + 4 * b), HBURST_INCR4, 1'b0);
      @(negedge HCLK);
      checks++;
      if (slv_HADDR !== AW'(16'h0040 + 4 * b) || mst_HREADYOUT[0] !== 1'b0 || mst_HREADYOUT[1] !== 1'b1) begin
        errors++; $display("FAIL burst_beat%0d: got addr %h rdy %b want %h rdy x10", b + 1, slv_HADDR, mst_HREADYOUT, AW'(16'h0040 + 4 * b));
      end
      tick();
    end
    set_m(1, 1'b0, HTRANS_IDLE, 1'b0, 16'h004C, HBURST_INCR4, 1'b0);
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT[0] !== 1'b0 || slv_HTRANS !== HTRANS_IDLE) begin errors++; $display("FAIL burst_grant_cycle: got rdy0 %b trans %b want 0 00", mst_HREADYOUT[0], slv_HTRANS); end
    tick();
    @(negedge HCLK);
    checks++; if (slv_HADDR !== 16'h0080 || mst_HREADYOUT[0] !== 1'b1) begin errors++; $display("FAIL burst_m0_after: got %h/%b want 0080/1", slv_HADDR, mst_HREADYOUT[0]); end
    set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0080, HBURST_SINGLE, 1'b0);
    tick();
  endtask

  task automatic test_lock();
    reset_dut();
    set_m(1, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0300, HBURST_SINGLE, 1'b0);
    for (int t = 0; t < 5; t++) begin
      if (t < 3)       set_m(0, 1'b1, HTRANS_NONSEQ, 1'b1, AW'(4 * t), HBURST_SINGLE, 1'b1);
      else if (t == 3) set_m(0, 1'b1, HTRANS_IDLE, 1'b0, 16'h0008, HBURST_SINGLE, 1'b1);
      else             set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0008, HBURST_SINGLE, 1'b0);
      @(negedge HCLK);
      checks++; if (mst_HREADYOUT[1] !== 1'b0) begin errors++; $display("FAIL lock_stall_t%0d: got %b want 0", t, mst_HREADYOUT[1]); end
      checks++; if (slv_HMASTLOCK !== lock[0] || slv_HADDR !== addr[0]) begin errors++; $display("FAIL lock_owner_t%0d: got lock %b addr %h want %b %h", t, slv_HMASTLOCK, slv_HADDR, lock[0], addr[0]); end
      tick();
    end
    @(negedge HCLK);
    checks++; if (mst_HREADYOUT[1] !== 1'b1 || slv_HADDR !== 16'h0300) begin errors++; $display("FAIL lock_release: got %b/%h want 1/0300", mst_HREADYOUT[1], slv_HADDR); end
    set_m(1, 1'b0, HTRANS_IDLE, 1'b0, 16'h0300, HBURST_SINGLE, 1'b0);
    tick();
  endtask

  task automatic test_wait_error();
    reset_dut();
    set_m(0, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0010, HBURST_SINGLE, 1'b0);
    tick();
    set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0010, HBURST_SINGLE, 1'b0);
    set_m(1, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0014, HBURST_SINGLE, 1'b0);
    s_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge HCLK);
      checks++; if (mst_HREADYOUT !== 3'b100) begin errors++; $display("FAIL wait%0d_ready: got %b want 100", w, mst_HREADYOUT); end
      checks++; if (slv_HADDR !== 16'h0010 || slv_HSEL !== 1'b0) begin errors++; $display("FAIL wait%0d_frozen: got %h/%b want 0010/0", w, slv_HADDR, slv_HSEL); end
      tick();
    end
    s_ready = 1'b1;
    @(negedge HCLK);
    checks++; if (mst_HRDATA !== 32'hCAFE_0001 || mst_HREADYOUT !== 3'b101) begin errors++; $display("FAIL wait_data: got %h/%b want cafe0001/101", mst_HRDATA, mst_HREADYOUT); end
    tick();
    @(negedge HCLK);
    checks++; if (slv_HADDR !== 16'h0014 || mst_HREADYOUT[1] !== 1'b1) begin errors++; $display("FAIL err_m1_addr: got %h/%b want 0014/1", slv_HADDR, mst_HREADYOUT[1]); end
    tick();
    set_m(1, 1'b0, HTRANS_IDLE, 1'b0, 16'h0014, HBURST_SINGLE, 1'b0);
    s_ready = 1'b0; s_resp = 1'b1;
    @(negedge HCLK);
    checks++; if (mst_HRESP !== 3'b010 || mst_HREADYOUT !== 3'b101) begin errors++; $display("FAIL err_cycle1: got resp %b rdy %b want 010 101", mst_HRESP, mst_HREADYOUT); end
    tick();
    s_ready = 1'b1;
    @(negedge HCLK);
    checks++; if (mst_HRESP !== 3'b010 || mst_HREADYOUT !== 3'b111) begin errors++; $display("FAIL err_cycle2: got resp %b rdy %b want 010 111", mst_HRESP, mst_HREADYOUT); end
    tick();
    s_resp = 1'b0;
    @(negedge HCLK);
    checks++; if (mst_HRESP !== 3'b000) begin errors++; $display("FAIL err_after: got %b want 000", mst_HRESP); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    set_m(0, 1'b0, HTRANS_IDLE, 1'b0, 16'h0999, HBURST_SINGLE, 1'b0);
    set_m(1, 1'b1, HTRANS_NONSEQ, 1'b0, 16'h0040, HBURST_INCR4, 1'b0);
    tick();
    tick();
    set_m(1, 1'b1, HTRANS_SEQ, 1'b0, 16'h0044, HBURST_INCR4, 1'b0);
    #2;
    checks++; if (slv_HADDR !== 16'h0044) begin errors++; $display("FAIL rmb_beat2: got %h want 0044", slv_HADDR); end
    idle_all();
    addr[0] = 16'h0999;
    s_ready = 1'b1; s_resp = 1'b1;
    HRESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (slv_HADDR !== 16'h0999) begin errors++; $display("FAIL rmb_owner0: got %h want 0999", slv_HADDR); end
    checks++; if (mst_HREADYOUT !== 3'b111 || mst_HRESP !== 3'b000) begin errors++; $display("FAIL rmb_ready_resp: got %b/%b want 111/000", mst_HREADYOUT, mst_HRESP); end
    s_ready = 1'b0;
    #1;
    checks++; if (mst_HREADYOUT !== 3'b110) begin errors++; $display("FAIL rmb_ready_wait: got %b want 110", mst_HREADYOUT); end
    s_ready = 1'b1; s_resp = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [M-1:0] er, ep;
    int           o, d;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < M; i++) begin
        set_m(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom),
              AW'($urandom), 3'($urandom), $urandom_range(0, 7) == 0);
        size[i]  = 3'($urandom);
        prot[i]  = 4'($urandom);
        wdata[i] = $urandom;
      end
      s_ready = $urandom_range(0, 3) != 0;
      s_resp  = $urandom_range(0, 7) == 0;
      @(negedge HCLK);
      o = m_owner; d = m_downer;
      er = '1; ep = '0;
      for (int i = 0; i < M; i++) begin er[i] = exp_ready(i); ep[i] = exp_resp(i); end
      checks++; if (mst_HREADYOUT !== er) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, mst_HREADYOUT, er); end
      checks++; if (mst_HRESP !== ep) begin errors++; $display("FAIL rnd_resp c%0d: got %b want %b", c, mst_HRESP, ep); end
      checks++; if (slv_HADDR !== addr[o]) begin errors++; $display("FAIL rnd_haddr c%0d: got %h want %h", c, slv_HADDR, addr[o]); end
      checks++; if (slv_HSEL !== sel[o] || slv_HTRANS !== (sel[o] ? trans[o] : HTRANS_IDLE)) begin errors++; $display("FAIL rnd_sel_trans c%0d: got %b/%b want %b/%b", c, slv_HSEL, slv_HTRANS, sel[o], sel[o] ? trans[o] : HTRANS_IDLE); end
      checks++;
      if ({slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HMASTLOCK} !== {wr[o], size[o], burst[o], prot[o], lock[o]}) begin
        errors++; $display("FAIL rnd_ctrl c%0d: got %h want %h", c, {slv_HWRITE, slv_HSIZE, slv_HBURST, slv_HPROT, slv_HMASTLOCK}, {wr[o], size[o], burst[o], prot[o], lock[o]});
      end
      checks++; if (slv_HWDATA !== wdata[d]) begin errors++; $display("FAIL rnd_hwdata c%0d: got %h want %h", c, slv_HWDATA, wdata[d]); end
      checks++; if (slv_HREADY !== s_ready) begin errors++; $display("FAIL rnd_hready c%0d: got %b want %b", c, slv_HREADY, s_ready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_contention();
    test_burst_hold();
    test_lock();
    test_wait_error();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
